// File: rtl/skolem_search_ctrl_if.sv
// ============================================================================
// Module   : skolem_search_ctrl_if
// Brief    : Query/result handshake bundle for the Skolem witness search.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface skolem_search_ctrl_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic [W-1:0] t;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic         found;
  logic [W:0]   evals;
  logic         abort;

  modport master (
    output in_valid, s, t, out_ready, abort,
    input  in_ready, out_valid, x, found, evals
  );

  modport slave (
    input  in_valid, s, t, out_ready, abort,
    output in_ready, out_valid, x, found, evals
  );
endinterface

`default_nettype wire

// File: rtl/skolem_search_ctrl.sv
// ============================================================================
// Module   : skolem_search_ctrl
// Brief    : Linear search for the smallest x with (x udiv s) >s t.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module skolem_search_ctrl #(
  parameter int W = 4
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  skolem_search_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [W-1:0] c_all_ones = {W{1'b1}};

  state_t       r_state;
  logic [W-1:0] r_s;
  logic [W-1:0] r_t;
  logic [W:0]   r_cnt;
  logic [W-1:0] r_x;
  logic         r_found;
  logic [W:0]   r_evals;

  logic [W-1:0] w_cand;
  logic [W-1:0] w_q;
  logic         w_pass;
  logic         w_last;

  assign w_cand = r_cnt[W-1:0];
  // Division by zero yields all ones, matching SMT-LIB bvudiv.
  assign w_q    = (r_s == '0) ? c_all_ones : (w_cand / r_s);
  assign w_pass = $signed(w_q) > $signed(r_t);
  assign w_last = (w_cand == c_all_ones);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_t     <= '0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_found <= 1'b0;
      r_evals <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_s     <= bus.s;
            r_t     <= bus.t;
            r_cnt   <= '0;
            r_state <= SEARCH;
          end
        end
        SEARCH: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (w_pass) begin
            r_x     <= w_cand;
            r_found <= 1'b1;
            r_evals <= r_cnt + 1'b1;
            r_state <= DONE;
          end else if (w_last) begin
            r_x     <= '0;
            r_found <= 1'b0;
            r_evals <= r_cnt + 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.x         = r_x;
  assign bus.found     = r_found;
  assign bus.evals     = r_evals;

endmodule

`default_nettype wire

// File: tb/tb_skolem_search_ctrl.sv
// ============================================================================
// Module   : tb_skolem_search_ctrl
// Brief    : Self-checking bench for skolem_search_ctrl (W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skolem_search_ctrl;
  localparam int W = 4;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  skolem_search_ctrl_if #(.W(W)) bus ();
  skolem_search_ctrl #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int s; int t; int x; int f; int e;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int to_signed_w(input int v);
    return (v >= N / 2) ? v - N : v;
  endfunction

  // Smallest c whose unsigned quotient, read as signed, exceeds signed t.
  function automatic void model(input int sv, input int tv,
                                output int ex, output int ef, output int ee);
    int q;
    ex = 0; ef = 0; ee = N;
    for (int c = 0; c < N; c++) begin
      q = (sv == 0) ? N - 1 : c / sv;
      if (to_signed_w(q) > to_signed_w(tv)) begin
        ex = c; ef = 1; ee = c + 1;
        return;
      end
    end
  endfunction

  task automatic start_query(input int sv, input int tv);
    int n;
    @(negedge clk);
    bus.s = W'(sv); bus.t = W'(tv); bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.s = W'($urandom);
    bus.t = W'($urandom);
  endtask

  // Counts cycles after the handshake until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < N + 5) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check("out_valid_timeout", int'(bus.out_valid), 1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_query(input int sv, input int tv, input int hold,
                           output int rx, output int rf, output int re, output int lat);
    start_query(sv, tv);
    wait_result(lat);
    rx = int'(bus.x); rf = int'(bus.found); re = int'(bus.evals);
    repeat (hold) @(negedge clk);
    consume();
  endtask

  initial begin
    int rx, rf, re, lat, ex, ef, ee, cnt, sv, tv;
    bus.in_valid = 1'b0; bus.s = '0; bus.t = '0;
    bus.out_ready = 1'b0; bus.abort = 1'b0;

    vecs[0] = '{s: 1, t: 0, x: 1, f: 1, e: 2};
    vecs[1] = '{s: 2, t: 3, x: 8, f: 1, e: 9};
    vecs[2] = '{s: 0, t: 8, x: 0, f: 1, e: 1};
    vecs[3] = '{s: 0, t: 0, x: 0, f: 0, e: 16};
    vecs[4] = '{s: 1, t: 7, x: 0, f: 0, e: 16};

    #1;
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_x", int'(bus.x), 0);
    check("reset_found", int'(bus.found), 0);
    check("reset_evals", int'(bus.evals), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_query(vecs[i].s, vecs[i].t, i, rx, rf, re, lat);
      check($sformatf("vec%0d_x", i), rx, vecs[i].x);
      check($sformatf("vec%0d_found", i), rf, vecs[i].f);
      check($sformatf("vec%0d_evals", i), re, vecs[i].e);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].e + 1);
    end

    // Result held stable while the consumer stalls.
    start_query(2, 3);
    wait_result(lat);
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
      check("hold_x", int'(bus.x), 8);
      check("hold_evals", int'(bus.evals), 9);
    end
    consume();

    // Result drain and new request in the same cycle.
    start_query(1, 0);
    wait_result(lat);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.s = 4'd2; bus.t = 4'd3;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("overlap_idle_ready", int'(bus.in_ready), 1);
    check("overlap_idle_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(lat);
    check("overlap_x", int'(bus.x), 8);
    check("overlap_latency", lat, 10);
    consume();

    // Abort in cycle 4 of a no-witness search.
    start_query(0, 0);
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(bus.in_ready), 1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("abort_no_result", cnt, 0);

    // Reset mid-search.
    start_query(0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_x", int'(bus.x), 0);
    check("midrst_found", int'(bus.found), 0);
    check("midrst_evals", int'(bus.evals), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_query(1, 0, 0, rx, rf, re, lat);
    check("postrst_x", rx, 1);
    check("postrst_evals", re, 2);
    check("postrst_latency", lat, 3);

    // Random queries against the reference model.
    for (int i = 0; i < 30; i++) begin
      sv = int'($urandom_range(0, N - 1));
      tv = int'($urandom_range(0, N - 1));
      model(sv, tv, ex, ef, ee);
      run_query(sv, tv, int'($urandom_range(0, 3)), rx, rf, re, lat);
      check($sformatf("rand%0d_x(s=%0d,t=%0d)", i, sv, tv), rx, ex);
      check($sformatf("rand%0d_found", i), rf, ef);
      check($sformatf("rand%0d_evals", i), re, ee);
      check($sformatf("rand%0d_latency", i), lat, ee + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
